// File: rtl/cr_xp10_decomp_htf_hdr_seq_pkg.sv
// Shared types and constants for the XP10 decompressor HTF header sequencer.
package cr_xp10_decompPKG;

   typedef enum logic [1:0] {
      HTF_HDR_SEQ_IDLE  = 2'd0,
      HTF_HDR_SEQ_OWN   = 2'd1,
      HTF_HDR_SEQ_CLEAR = 2'd2
   } htf_hdr_seq_state_e;

   localparam int HTF_HDR_SEQ_WDOG_W = 16;

   // Bits needed to hold values 0..n-1; never less than one bit.
   function automatic int log_vec(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cr_xp10_decomp_rr_arb.sv
// N-way round-robin picker: first set request at or after ptr wins, one-hot result.
module cr_xp10_decomp_rr_arb
   import cr_xp10_decompPKG::*;
#(
   parameter int N  = 2,
   parameter int PW = log_vec(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   always_comb begin
      logic found;
      int   idx;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cr_xp10_decomp_htf_hdr_seq.sv
// HTF header bit-stream sequencer: round-robin ownership of the unpacker consume port
// and flush pulse generation. Optional stall watchdog: CR_XP10_DECOMP_HTF_HDR_SEQ_WDOG_EN.
module cr_xp10_decomp_htf_hdr_seq
   import cr_xp10_decompPKG::*;
#(
   parameter int N_REQ                  = 2,
   parameter int MAX_HDR_BITS_PER_CYCLE = 16,
   parameter int WDOG_LIMIT             = 1024,
   localparam int CW = log_vec(MAX_HDR_BITS_PER_CYCLE + 1),
   localparam int PW = log_vec(N_REQ)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [CW-1:0]                     hdr_bits_avail,
   input  logic [MAX_HDR_BITS_PER_CYCLE-1:0] hdr_bits_data,
   input  logic                              hdr_bits_last,
   input  logic                              hdr_bits_err,
   output logic [CW-1:0]                     hdr_bits_consume,
   output logic                              hdr_clear,
   input  logic [N_REQ-1:0]                  req,
   input  logic [N_REQ-1:0]                  done,
   input  logic [N_REQ-1:0]                  abort,
   input  logic [N_REQ*CW-1:0]               req_consume,
   output logic [N_REQ-1:0]                  grant,
   output logic [CW-1:0]                     own_bits_avail,
   output logic [MAX_HDR_BITS_PER_CYCLE-1:0] own_bits_data,
   output logic                              own_bits_last,
   input  logic                              ext_clear,
   output logic                              seq_err_stb,
   output logic                              wdog_stb
);

   htf_hdr_seq_state_e state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d, win;
   logic [PW-1:0]    rr_ptr_q, rr_ptr_d, win_idx;
   logic [CW-1:0]    owner_consume;
   logic             in_own, owner_done, owner_abort;
   logic             err_seen_q, hdr_clear_q, seq_err_stb_q, wdog_fire;

   cr_xp10_decomp_rr_arb #(.N(N_REQ), .PW(PW)) u_arb (
      .req (req),
      .ptr (rr_ptr_q),
      .gnt (win)
   );

   always_comb begin
      win_idx       = '0;
      owner_consume = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win[i])     win_idx = PW'(i);
         if (grant_q[i]) owner_consume = owner_consume | req_consume[i*CW +: CW];
      end
   end

   assign in_own           = (state_q == HTF_HDR_SEQ_OWN);
   assign owner_done       = |(done & grant_q);
   assign owner_abort      = |(abort & grant_q);
   assign hdr_bits_consume = in_own ? owner_consume : '0;
   assign own_bits_avail   = in_own ? hdr_bits_avail : '0;
   assign own_bits_data    = in_own ? hdr_bits_data : '0;
   assign own_bits_last    = in_own & hdr_bits_last;
   assign grant            = grant_q;
   assign hdr_clear        = hdr_clear_q;
   assign seq_err_stb      = seq_err_stb_q;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         HTF_HDR_SEQ_IDLE: begin
            grant_d = '0;
            if (|req) begin
               state_d  = HTF_HDR_SEQ_OWN;
               grant_d  = win;
               rr_ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
            end
         end
         HTF_HDR_SEQ_OWN: begin
            if (wdog_fire) begin
               state_d = HTF_HDR_SEQ_CLEAR;
               grant_d = '0;
            end else if (owner_done) begin
               // An error in the release cycle itself still forces a flush.
               state_d = (owner_abort || err_seen_q || hdr_bits_err) ? HTF_HDR_SEQ_CLEAR
                                                                     : HTF_HDR_SEQ_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = HTF_HDR_SEQ_IDLE;
            grant_d = '0;
         end
      endcase
      if (ext_clear) begin
         state_d  = HTF_HDR_SEQ_CLEAR;
         grant_d  = '0;
         rr_ptr_d = rr_ptr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HTF_HDR_SEQ_IDLE;
         grant_q       <= '0;
         rr_ptr_q      <= '0;
         err_seen_q    <= 1'b0;
         hdr_clear_q   <= 1'b0;
         seq_err_stb_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         rr_ptr_q      <= rr_ptr_d;
         hdr_clear_q   <= (state_d == HTF_HDR_SEQ_CLEAR);
         seq_err_stb_q <= in_own & hdr_bits_err;
         if (state_q == HTF_HDR_SEQ_CLEAR) err_seen_q <= 1'b0;
         else if (in_own && hdr_bits_err) err_seen_q <= 1'b1;
      end
   end

`ifdef CR_XP10_DECOMP_HTF_HDR_SEQ_WDOG_EN
   logic [HTF_HDR_SEQ_WDOG_W-1:0] wdog_cnt_q;
   logic                          wdog_stb_q, stall;

   assign stall     = in_own && (hdr_bits_avail != '0) && (hdr_bits_consume == '0);
   // Fire on the stalled cycle that would bring the count to the limit.
   assign wdog_fire = stall && (wdog_cnt_q == HTF_HDR_SEQ_WDOG_W'(WDOG_LIMIT - 1));
   assign wdog_stb  = wdog_stb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt_q <= '0;
         wdog_stb_q <= 1'b0;
      end else begin
         wdog_stb_q <= wdog_fire;
         if (!in_own || state_d != HTF_HDR_SEQ_OWN || hdr_bits_consume != '0)
            wdog_cnt_q <= '0;
         else if (stall)
            wdog_cnt_q <= wdog_cnt_q + 1'b1;
      end
   end
`else
   logic [31:0] unused_wdog_limit;
   assign unused_wdog_limit = 32'(WDOG_LIMIT);
   assign wdog_fire         = 1'b0;
   assign wdog_stb          = 1'b0;
`endif

endmodule

// File: tb/tb_cr_xp10_decomp_htf_hdr_seq.sv
// Directed self-checking bench for the HTF header sequencer (N_REQ=2, 16-bit window).
module tb_cr_xp10_decomp_htf_hdr_seq;

   localparam int N   = 2;
   localparam int MB  = 16;
   localparam int CW  = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] hdr_bits_avail;
   logic [MB-1:0] hdr_bits_data;
   logic          hdr_bits_last, hdr_bits_err;
   logic [CW-1:0] hdr_bits_consume;
   logic          hdr_clear;
   logic [N-1:0]  req, done, abort, grant;
   logic [N*CW-1:0] req_consume;
   logic [CW-1:0] own_bits_avail;
   logic [MB-1:0] own_bits_data;
   logic          own_bits_last, ext_clear, seq_err_stb, wdog_stb;

   int total = 0;
   int fails = 0;

   cr_xp10_decomp_htf_hdr_seq #(
      .N_REQ(N), .MAX_HDR_BITS_PER_CYCLE(MB), .WDOG_LIMIT(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .hdr_bits_avail(hdr_bits_avail), .hdr_bits_data(hdr_bits_data),
      .hdr_bits_last(hdr_bits_last), .hdr_bits_err(hdr_bits_err),
      .hdr_bits_consume(hdr_bits_consume), .hdr_clear(hdr_clear),
      .req(req), .done(done), .abort(abort), .req_consume(req_consume),
      .grant(grant), .own_bits_avail(own_bits_avail), .own_bits_data(own_bits_data),
      .own_bits_last(own_bits_last), .ext_clear(ext_clear),
      .seq_err_stb(seq_err_stb), .wdog_stb(wdog_stb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; req = '0; done = '0; abort = '0; ext_clear = 1'b0;
      hdr_bits_avail = 5'd16; hdr_bits_data = 16'hA5A5; hdr_bits_last = 1'b0;
      hdr_bits_err = 1'b0; req_consume = {5'd0, 5'd8};
      #2;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_clear", 32'(hdr_clear), 32'h0);
      chk("rst_seq_err", 32'(seq_err_stb), 32'h0);
      chk("rst_wdog", 32'(wdog_stb), 32'h0);
      chk("rst_consume", 32'(hdr_bits_consume), 32'h0);
      chk("rst_own_avail", 32'(own_bits_avail), 32'h0);
      tick(); tick(); rst_n = 1'b1;

      // Grant and forward
      tick(); req = 2'b01; #1;
      chk("idle_grant", 32'(grant), 32'h0);
      chk("idle_consume", 32'(hdr_bits_consume), 32'h0);
      tick(); hdr_bits_last = 1'b1; #1;
      chk("g0_grant", 32'(grant), 32'h1);
      chk("g0_consume1", 32'(hdr_bits_consume), 32'd8);
      chk("g0_own_avail", 32'(own_bits_avail), 32'd16);
      chk("g0_own_data", 32'(own_bits_data), 32'hA5A5);
      chk("g0_own_last", 32'(own_bits_last), 32'h1);
      tick(); hdr_bits_last = 1'b0; #1;
      chk("g0_consume2", 32'(hdr_bits_consume), 32'd8);
      tick(); done = 2'b01; #1;
      chk("g0_consume3", 32'(hdr_bits_consume), 32'd8);
      tick(); done = '0; req = '0; #1;
      chk("g0_release", 32'(grant), 32'h0);
      chk("g0_no_clear", 32'(hdr_clear), 32'h0);
      chk("g0_rel_consume", 32'(hdr_bits_consume), 32'h0);
      chk("g0_rel_own_avail", 32'(own_bits_avail), 32'h0);

      // Round-robin: pointer is at 1 after parser 0 was served
      tick(); req = 2'b11; #1;
      chk("rr_idle", 32'(grant), 32'h0);
      tick(); #1;
      chk("rr_g1", 32'(grant), 32'h2);
      tick(); done = 2'b10; #1;
      tick(); done = '0; #1;
      chk("rr_gap1", 32'(grant), 32'h0);
      tick(); #1;
      chk("rr_g0", 32'(grant), 32'h1);
      tick(); done = 2'b01; #1;
      tick(); done = '0; #1;
      chk("rr_gap2", 32'(grant), 32'h0);
      tick(); #1;
      chk("rr_g1b", 32'(grant), 32'h2);

      // Abort release by parser 1
      tick(); done = 2'b10; abort = 2'b10; #1;
      chk("ab_pre_clear", 32'(hdr_clear), 32'h0);
      tick(); done = '0; abort = '0; #1;
      chk("ab_clear", 32'(hdr_clear), 32'h1);
      chk("ab_grant", 32'(grant), 32'h0);
      tick(); #1;
      chk("ab_clear_end", 32'(hdr_clear), 32'h0);
      chk("ab_gap", 32'(grant), 32'h0);
      tick(); #1;
      chk("ab_regrant", 32'(grant), 32'h1);

      // Consume error, then a plain release
      tick(); hdr_bits_err = 1'b1; req = '0; #1;
      chk("er_stb_pre", 32'(seq_err_stb), 32'h0);
      tick(); hdr_bits_err = 1'b0; #1;
      chk("er_stb", 32'(seq_err_stb), 32'h1);
      chk("er_grant", 32'(grant), 32'h1);
      tick(); done = 2'b01; #1;
      chk("er_stb_once", 32'(seq_err_stb), 32'h0);
      tick(); done = '0; #1;
      chk("er_clear", 32'(hdr_clear), 32'h1);
      chk("er_grant_rel", 32'(grant), 32'h0);
      tick(); #1;
      chk("er_clear_end", 32'(hdr_clear), 32'h0);

      // External clear and non-owner isolation (pointer now at 1)
      tick(); req = 2'b10; #1;
      tick(); req = '0; req_consume = {5'd3, 5'd16}; #1;
      chk("ex_grant", 32'(grant), 32'h2);
      chk("ex_isolation", 32'(hdr_bits_consume), 32'd3);
      ext_clear = 1'b1;
      tick(); #1;
      chk("ex_grant_drop", 32'(grant), 32'h0);
      chk("ex_clear", 32'(hdr_clear), 32'h1);
      tick(); ext_clear = 1'b0; #1;
      chk("ex_clear_again", 32'(hdr_clear), 32'h1);
      tick(); #1;
      chk("ex_clear_end", 32'(hdr_clear), 32'h0);

      // Stall with data available and zero consume (pointer now at 0)
      tick(); req = 2'b01; req_consume = '0; hdr_bits_avail = 5'd16; #1;
      tick(); req = '0; #1;
      chk("wd_grant", 32'(grant), 32'h1);
      tick(); tick(); tick(); #1;
      chk("wd_stall4_clear", 32'(hdr_clear), 32'h0);
      chk("wd_stall4_stb", 32'(wdog_stb), 32'h0);
      tick(); #1;
`ifdef CR_XP10_DECOMP_HTF_HDR_SEQ_WDOG_EN
      chk("wd_fire_clear", 32'(hdr_clear), 32'h1);
      chk("wd_fire_stb", 32'(wdog_stb), 32'h1);
      chk("wd_fire_grant", 32'(grant), 32'h0);
      tick(); #1;
      chk("wd_stb_pulse", 32'(wdog_stb), 32'h0);
`else
      chk("wd_off_clear", 32'(hdr_clear), 32'h0);
      chk("wd_off_stb", 32'(wdog_stb), 32'h0);
      chk("wd_off_grant", 32'(grant), 32'h1);
      done = 2'b01;
      tick(); done = '0; #1;
      chk("wd_off_release", 32'(grant), 32'h0);
`endif

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/cr_xp10_decomp_htf_hdr_seq.md
# cr_xp10_decomp_htf_hdr_seq

Sequencer and arbiter for the HTF header bit stream. It owns the `hdr_bits_*` consume interface of the header FIFO/unpacker and shares it between `N_REQ` header parsers, such as the frame-header parser and the Huffman-table parser. Only one parser holds the stream at a time, and it keeps it until it signals done. The block also issues the single-cycle `hdr_clear` that flushes the FIFO and unpacker after an abort, a consume error, an external flush, or a watchdog timeout.

## Interface
Parameters:
- N_REQ, 2, number of header parsers (2..4).
- MAX_HDR_BITS_PER_CYCLE, 16, width of the bit window.
- WDOG_LIMIT, 1024, stall cycles before a forced clear (used only when the watchdog is compiled in).

Ports (CW = `LOG_VEC(MAX_HDR_BITS_PER_CYCLE+1)` width):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- hdr_bits_avail  in  CW  bits valid at the unpacker output.
- hdr_bits_data  in  MAX_HDR_BITS_PER_CYCLE  unpacker window.
- hdr_bits_last  in  1  end of header stream.
- hdr_bits_err  in  1  consume exceeded avail.
- hdr_bits_consume  out  CW  consume count sent to the unpacker.
- hdr_clear  out  1  flush pulse to the FIFO and unpacker.
- req  in  N_REQ  level request per parser.
- done  in  N_REQ  per-parser release pulse.
- abort  in  N_REQ  qualifies `done`; request a flush on release.
- req_consume  in  N_REQ*CW  per-parser consume, flattened (parser i at [i*CW +: CW]).
- grant  out  N_REQ  registered one-hot owner.
- own_bits_avail  out  CW  `hdr_bits_avail` gated to 0 unless in OWN.
- own_bits_data  out  MAX_HDR_BITS_PER_CYCLE  `hdr_bits_data` gated likewise.
- own_bits_last  out  1  `hdr_bits_last` gated likewise.
- ext_clear  in  1  upstream frame flush.
- seq_err_stb  out  1  registered pulse: a consume error was seen in OWN.
- wdog_stb  out  1  registered pulse: the watchdog fired.

## Operation
State machine: IDLE, OWN, CLEAR.
- **IDLE**
  - No grant; `hdr_bits_consume` = 0.
  - If any `req` is set, pick the winner round-robin, starting at `rr_ptr`.
  - Register the winner into `grant`, set `rr_ptr` = winner+1 mod N_REQ, go to OWN.
- **OWN**
  - `hdr_bits_consume` = the owner's `req_consume` slice. Slices from other parsers are ignored.
  - `own_*` outputs pass through combinationally.
  - On `hdr_bits_err`: set the sticky `err_seen` flag and pulse `seq_err_stb` on the next cycle.
  - On owner `done`:
    - If `abort` or `err_seen` (including an error in the same cycle): go to CLEAR.
    - Otherwise: go to IDLE.
  - `done`/`abort` from a non-owner is ignored.
  - The owner's consume in its `done` cycle is still forwarded.
- **CLEAR**
  - `hdr_clear` = 1 for exactly one cycle; `grant` = 0; consume = 0.
  - Clear `err_seen`; go to IDLE.
- `ext_clear` in any state: the next state is CLEAR and `grant` drops.
  - `ext_clear` during CLEAR: exactly one more CLEAR cycle follows.
- `hdr_clear` is a registered state decode: it is high iff state == CLEAR.

## Timing
- Reset values: state IDLE, `grant` 0, `rr_ptr` 0, `err_seen` 0, `hdr_clear` 0, `seq_err_stb` 0, `wdog_stb` 0, watchdog count 0.
- Combinational outputs (`hdr_bits_consume`, `own_*`) are 0 during reset.
- `req` in cycle t (state IDLE): `grant` is high in t+1, and the owner may consume in t+1.
- `done` in cycle t: `grant` is low in t+1.
  - Normal release: the next owner can be granted no earlier than t+2.
  - Flushing release: `hdr_clear` is high in t+1, and the earliest new grant is t+3.
- Minimum gap between owners is one IDLE cycle.
- Reset mid-OWN drops `grant` asynchronously. No clear is issued; the FIFO shares the same reset.

## Configuration
- Macro: `CR_XP10_DECOMP_HTF_HDR_SEQ_WDOG_EN`.
- Defined:
  - A 16-bit counter runs in OWN. It increments while `hdr_bits_avail` != 0 and the forwarded consume == 0.
  - It resets to 0 on any nonzero consume or on leaving OWN.
  - At WDOG_LIMIT it forces CLEAR and pulses `wdog_stb` in the same cycle `hdr_clear` rises.
- Undefined: no counter is instantiated, `wdog_stb` is tied to 0, and WDOG_LIMIT is unused.

## Structure
- Add `htf_hdr_seq_state_e` (IDLE/OWN/CLEAR) to cr_xp10_decompPKG.
- Add `HTF_HDR_SEQ_WDOG_W` = 16 to cr_xp10_decompPKG.
- Sub-module: cr_xp10_decomp_rr_arb — an N-way round-robin picker taking a request vector and pointer, returning a one-hot result; it is reusable.
- The FSM, consume mux and watchdog stay in this module.

## Test plan
- Grant and forward:
  - Stimulus: `req`=01, then parser 0 consumes 8 for 3 cycles, then `done`.
  - Response: `grant`=01 one cycle after `req`; `hdr_bits_consume`=8 ×3; `grant`=00 after `done`; no `hdr_clear`.
- Round-robin:
  - Stimulus: `req`=11 held, each owner releases after 2 cycles.
  - Response: grants alternate 01, 10, 01 with one IDLE cycle between each.
- Abort:
  - Stimulus: owner 1 asserts `done`+`abort`.
  - Response: `hdr_clear`=1 for exactly one cycle; next grant no earlier than 2 cycles after `hdr_clear`.
- Error:
  - Stimulus: `hdr_bits_err` in OWN, later a plain `done`.
  - Response: `seq_err_stb` pulses once; the release still produces `hdr_clear`.
- External clear and isolation:
  - `ext_clear` mid-OWN → `grant` drops and `hdr_clear` rises next cycle.
  - A non-owner consume of 16 → `hdr_bits_consume` stays equal to the owner's value.
- Watchdog (macro defined, WDOG_LIMIT=4):
  - Stimulus: avail=16 held with zero consume.
  - Response: `hdr_clear` and `wdog_stb` rise on the 5th stalled cycle (count reaches 4).
